// File: rtl/freq_pair_sequencer.sv
// Streams reference/song frequency pairs from a small register table into a FIFO.
// Build option FREQ_SEQ_LOOP_EN enables continuous looping of passes under loop_en.
module freq_pair_sequencer #(
    parameter int FREQ_W = 15,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tbl_we,
    input  logic [IDX_W-1:0]  tbl_addr,
    input  logic [FREQ_W-1:0] tbl_ref,
    input  logic [FREQ_W-1:0] tbl_song,
    input  logic [IDX_W:0]    len,
    input  logic              start,
    input  logic              abort,
    input  logic              loop_en,
    input  logic              full,
    output logic              wr_en,
    output logic [FREQ_W-1:0] ref_freq,
    output logic [FREQ_W-1:0] song_freq,
    output logic [IDX_W-1:0]  index,
    output logic              busy,
    output logic              done,
    output logic [7:0]        pass_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ONE   = 1;
    localparam logic [IDX_W:0]   LEN_ONE   = 1;
    localparam logic [IDX_W:0]   DEPTH_LEN = DEPTH[IDX_W:0];

    state_t            state_q;
    logic [IDX_W-1:0]  index_q;
    logic [IDX_W:0]    len_q;
    logic [7:0]        pass_cnt_q;
    logic              done_q;

    logic [FREQ_W-1:0] ref_mem  [DEPTH];
    logic [FREQ_W-1:0] song_mem [DEPTH];

    logic last_write;
    logic loop_active;

`ifdef FREQ_SEQ_LOOP_EN
    assign loop_active = loop_en;
`else
    logic unused_loop_en;
    assign unused_loop_en = loop_en;
    assign loop_active    = 1'b0;
`endif

    assign wr_en      = (state_q == RUN) & ~full & ~abort;
    assign last_write = wr_en & ({1'b0, index_q} == (len_q - LEN_ONE));
    assign ref_freq   = ref_mem[index_q];
    assign song_freq  = song_mem[index_q];
    assign index      = index_q;
    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign pass_cnt   = pass_cnt_q;

    // Table is deliberately unreset so contents survive resets and passes.
    always_ff @(posedge clk) begin
        if (tbl_we && (state_q == IDLE) && ({1'b0, tbl_addr} < DEPTH_LEN)) begin
            ref_mem[tbl_addr]  <= tbl_ref;
            song_mem[tbl_addr] <= tbl_song;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            index_q    <= '0;
            len_q      <= DEPTH_LEN;
            pass_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q    <= RUN;
                        index_q    <= '0;
                        pass_cnt_q <= '0;
                        // Zero or oversized lengths fall back to the whole table.
                        if ((len == '0) || (len > DEPTH_LEN)) len_q <= DEPTH_LEN;
                        else                                  len_q <= len;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        index_q <= '0;
                    end else if (last_write) begin
                        index_q <= '0;
                        done_q  <= 1'b1;
                        if (pass_cnt_q != 8'hFF) pass_cnt_q <= pass_cnt_q + 8'd1;
                        if (!loop_active) state_q <= IDLE;
                    end else if (wr_en) begin
                        index_q <= index_q + IDX_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
